// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding and
// parity-sense constants.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator: running parity of the bits enabled since the last clear.
module parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    acc <= 1'b0;
    else if (clr) acc <= 1'b0;
    else if (en)  acc <= acc ^ d;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial frame receiver: DATA_W bits LSB-first plus one parity bit, reporting
// the word, expected parity and a mismatch flag with a one-cycle done pulse.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int   DATA_W = 8,
  parameter logic ODD    = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_out,
  output logic              parity_err,
  output logic              done
);

  localparam int              CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  shreg;
  logic               acc;
  logic               frame_clr;
  logic               bit_take;
  logic               parity_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt   = state;
    frame_clr   = 1'b0;
    bit_take    = 1'b0;
    parity_take = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DATA;
          frame_clr = 1'b1;
        end
      end
      DATA: begin
        if (bit_valid) begin
          bit_take = 1'b1;
          if (count == LAST) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          parity_take = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter saturates on the last data bit so it never wraps inside a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      shreg <= '0;
    end else if (frame_clr) begin
      count <= '0;
      shreg <= '0;
    end else if (bit_take) begin
      shreg[count] <= bit_in;
      if (count != LAST) count <= count + 1'b1;
    end
  end

  parity_acc u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_clr),
    .en    (bit_take),
    .d     (bit_in),
    .acc   (acc)
  );

  // Result registers only load on the parity bit, so partial frames never show.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      parity_out <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= parity_take;
      if (parity_take) begin
        data_out   <= shreg;
        parity_out <= acc ^ ODD;
        parity_err <= acc ^ ODD ^ bit_in;
      end
    end
  end

endmodule
